// File: rtl/spart_core.sv
// spart_core: bus-mapped 8N1 serial port (TX/RX buffers, status, 16-bit baud divisor).
// Define SPART_ERR_FLAGS_EN to add sticky framing/overrun flags in status bits 2 and 3.
module spart_core #(
  parameter logic [15:0] DEFAULT_DIV = 16'h28B1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       tbr,
  output logic       rda,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic        wr_en, wr_buf, rd_buf, rd_stat;
  logic [15:0] divisor_reg, eff_div;
  logic [7:0]  status, rd_data;

  assign wr_en   = iocs & ~iorw;
  assign wr_buf  = wr_en & (ioaddr == 2'b00);
  assign rd_buf  = iocs & iorw & (ioaddr == 2'b00);
  assign rd_stat = iocs & iorw & (ioaddr == 2'b01);

  // Divisors of 0 or 1 would make zero-length bits, so clamp to 2.
  assign eff_div = (divisor_reg < 16'd2) ? 16'd2 : divisor_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor_reg <= DEFAULT_DIV;
    end else if (wr_en && ioaddr == 2'b10) begin
      divisor_reg[7:0] <= databus;
    end else if (wr_en && ioaddr == 2'b11) begin
      divisor_reg[15:8] <= databus;
    end
  end

  // ---------------- transmitter ----------------
  state_t      tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic        txd_reg, txd_next;
  logic        tbr_reg, tbr_next;
  logic        tx_done;

  assign tx_done = (tx_state_reg == STOP) && (tx_cnt_reg == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      txd_reg      <= 1'b1;
      tbr_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
      tbr_reg      <= tbr_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    tbr_next      = tbr_reg;
    case (tx_state_reg)
      START: begin
        if (tx_cnt_reg == 16'd0) begin
          tx_state_next = DATA;
          txd_next      = tx_shift_reg[0];
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_bit_next   = 3'd0;
          tx_cnt_next   = eff_div - 16'd1;
        end else begin
          tx_cnt_next = tx_cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (tx_cnt_reg == 16'd0) begin
          tx_cnt_next = eff_div - 16'd1;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = STOP;
            txd_next      = 1'b1;
          end else begin
            txd_next      = tx_shift_reg[0];
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_bit_next   = tx_bit_reg + 3'd1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (tx_done) begin
          tx_state_next = IDLE;
          tbr_next      = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt_reg - 16'd1;
        end
      end
      default: ;
    endcase
    // A write landing on the stop-ending edge chains the next frame with no idle gap.
    if (wr_buf && (tbr_reg || tx_done)) begin
      tx_state_next = START;
      tx_shift_next = databus;
      tx_cnt_next   = eff_div - 16'd1;
      txd_next      = 1'b0;
      tbr_next      = 1'b0;
    end
  end

  assign txd = txd_reg;
  assign tbr = tbr_reg;

  // ---------------- receiver ----------------
  logic [SYNC_N-1:0] sync_reg;
  logic              rx_s, rx_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_N-2:0], rxd};
      rx_prev_reg <= rx_s;
    end
  end

  assign rx_s = sync_reg[SYNC_N-1];

  state_t      rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  rx_buf_reg, rx_buf_next;
  logic        rda_reg, rda_next;
  logic        rx_stop_sample, rx_done;

  assign rx_stop_sample = (rx_state_reg == STOP) && (rx_cnt_reg == 16'd0);
  assign rx_done        = rx_stop_sample & rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= 16'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'h00;
      rx_buf_reg   <= 8'h00;
      rda_reg      <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_buf_reg   <= rx_buf_next;
      rda_reg      <= rda_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_buf_next   = rx_buf_reg;
    rda_next      = rda_reg;
    case (rx_state_reg)
      IDLE: begin
        if (rx_prev_reg && !rx_s) begin
          rx_state_next = START;
          rx_cnt_next   = {1'b0, eff_div[15:1]} - 16'd1;
        end
      end
      START: begin
        if (rx_cnt_reg == 16'd0) begin
          rx_state_next = rx_s ? IDLE : DATA;
          rx_cnt_next   = eff_div - 16'd1;
          rx_bit_next   = 3'd0;
        end else begin
          rx_cnt_next = rx_cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (rx_cnt_reg == 16'd0) begin
          rx_shift_next = {rx_s, rx_shift_reg[7:1]};
          rx_cnt_next   = eff_div - 16'd1;
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (rx_stop_sample) rx_state_next = IDLE;
        else rx_cnt_next = rx_cnt_reg - 16'd1;
      end
      default: ;
    endcase
    if (rd_buf) rda_next = 1'b0;
    // Completion outranks a same-edge read-clear.
    if (rx_done) begin
      rda_next    = 1'b1;
      rx_buf_next = rx_shift_reg;
    end
  end

  assign rda = rda_reg;

`ifdef SPART_ERR_FLAGS_EN
  logic fe_reg, ovr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fe_reg  <= 1'b0;
      ovr_reg <= 1'b0;
    end else begin
      fe_reg  <= (fe_reg & ~rd_stat) | (rx_stop_sample & ~rx_s);
      ovr_reg <= (ovr_reg & ~rd_stat) | (rx_done & rda_reg & ~rd_buf);
    end
  end

  assign status = {4'b0000, ovr_reg, fe_reg, rda_reg, tbr_reg};
`else
  assign status = {6'b000000, rda_reg, tbr_reg};
`endif

  assign rd_data = ioaddr[0] ? status : rx_buf_reg;
  assign databus = (rd_buf || rd_stat) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_spart_core.sv
// Directed self-checking bench for spart_core: bus decode, TX framing, RX frames,
// false start, overrun, framing error and reset in the middle of a transmission.
`timescale 1ns/1ps
module tb_spart_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  tri1  [7:0] databus;
  logic       tbr, rda, txd;

  int total = 0;
  int passed = 0;

  assign databus = drv_en ? drv_data : 8'hzz;

  always #5 clk = ~clk;

  spart_core dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .tbr     (tbr),
    .rda     (rda),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a; drv_en = 1'b0;
    #2 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
    $display("rd addr=%0d data=%h", a, d);
  endtask

  // One 8N1 frame at 16 clocks per bit; stop_bit=0 forces a framing error.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = frame[i];
      repeat (15) @(negedge clk);
    end
    rxd = 1'b1;
    $display("rx frame data=%h stop=%0d", b, stop_bit);
  endtask

  logic [7:0] d;
  logic [9:0] exp_frame;
  logic [7:0] exp_ovr_stat, exp_fe_stat;

  initial begin
`ifdef SPART_ERR_FLAGS_EN
    exp_ovr_stat = 8'h0B;
    exp_fe_stat  = 8'h05;
`else
    exp_ovr_stat = 8'h03;
    exp_fe_stat  = 8'h01;
`endif
    repeat (3) @(negedge clk);
    check("rst_txd", {7'd0, txd}, 8'h01);
    check("rst_tbr", {7'd0, tbr}, 8'h01);
    check("rst_rda", {7'd0, rda}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    bus_rd(2'b01, d); check("status_rst", d, 8'h01);
    bus_rd(2'b10, d); check("rd_addr10_z", d, 8'hFF);
    bus_rd(2'b11, d); check("rd_addr11_z", d, 8'hFF);
    bus_rd(2'b00, d); check("rxbuf_rst", d, 8'h00);
    check("txd_idle", {7'd0, txd}, 8'h01);

    // Transmit A5 at divisor 16: every bit checked on its first and last cycle.
    bus_wr(2'b10, 8'h10);
    bus_wr(2'b11, 8'h00);
    bus_wr(2'b00, 8'hA5);
    check("tbr_busy", {7'd0, tbr}, 8'h00);
    exp_frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("txA5_b%0d_first", k), {7'd0, txd}, {7'd0, exp_frame[k]});
      repeat (15) @(negedge clk);
      check($sformatf("txA5_b%0d_last", k), {7'd0, txd}, {7'd0, exp_frame[k]});
      if (k == 9) check("tbr_before_160", {7'd0, tbr}, 8'h00);
      @(negedge clk);
    end
    check("tbr_at_160", {7'd0, tbr}, 8'h01);

    // Receive 3C, read it back, read clears rda.
    send_byte(8'h3C, 1'b1);
    check("rda_3c", {7'd0, rda}, 8'h01);
    bus_rd(2'b00, d); check("rx_3c", d, 8'h3C);
    check("rda_cleared", {7'd0, rda}, 8'h00);

    // 5-cycle glitch is a false start.
    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_rda", {7'd0, rda}, 8'h00);
    bus_rd(2'b01, d); check("glitch_status", d, 8'h01);

    // Overrun: second byte overwrites the first.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("ovr_rda", {7'd0, rda}, 8'h01);
    bus_rd(2'b01, d); check("ovr_status", d, exp_ovr_stat);
    bus_rd(2'b00, d); check("ovr_data", d, 8'h22);
    bus_rd(2'b01, d); check("ovr_status_clr", d, 8'h01);

    // Framing error: byte discarded, buffer keeps old value.
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    check("fe_rda", {7'd0, rda}, 8'h00);
    bus_rd(2'b01, d); check("fe_status", d, exp_fe_stat);
    bus_rd(2'b01, d); check("fe_status_clr", d, 8'h01);
    bus_rd(2'b00, d); check("fe_buf_kept", d, 8'h22);

    // Reset during data bit 3 of C3 (bit 3 = 0).
    bus_wr(2'b00, 8'hC3);
    repeat (70) @(negedge clk);
    check("pre_rst_txd", {7'd0, txd}, 8'h00);
    rst = 1'b0;
    #1;
    check("mid_rst_txd", {7'd0, txd}, 8'h01);
    check("mid_rst_tbr", {7'd0, tbr}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    bus_rd(2'b01, d); check("post_rst_status", d, 8'h01);
    bus_rd(2'b00, d); check("post_rst_rxbuf", d, 8'h00);

    // Clean 5A frame; an immediate second write while busy must be dropped.
    bus_wr(2'b10, 8'h10);
    bus_wr(2'b11, 8'h00);
    bus_wr(2'b00, 8'h5A);
    bus_wr(2'b00, 8'hFF);
    repeat (6) @(negedge clk);
    exp_frame = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx5A_b%0d", k), {7'd0, txd}, {7'd0, exp_frame[k]});
      if (k < 9) repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("tx5A_tbr_done", {7'd0, tbr}, 8'h01);
    repeat (20) @(negedge clk);
    check("tx5A_idle_txd", {7'd0, txd}, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
